// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_pkg
// Purpose  : Shared types and helpers for the edge-list store.
//            - state_e: controller states (INIT, IDLE, SCAN, DRAIN)
//            - empty_code(): the reserved EMPTY slot code for a vertex width
//            - pack_edge/edge_hi/edge_lo: {va, vb} pack and unpack helpers
//            The helpers work on 32-bit containers (VW <= 16), and callers
//            size-cast the results down to their own widths.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package edge_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // All ones over 2*vw bits. This code reads as a self-loop, so append can
  // never produce it.
  function automatic logic [31:0] empty_code(input int vw);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 2 * vw) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_edge(input logic [15:0] va,
                                            input logic [15:0] vb,
                                            input int vw);
    return (32'(va) << vw) | 32'(vb);
  endfunction

  function automatic logic [15:0] edge_hi(input logic [31:0] e, input int vw);
    return 16'(e >> vw);
  endfunction

  function automatic logic [15:0] edge_lo(input logic [31:0] e, input int vw);
    return 16'(e & ((32'd1 << vw) - 32'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_list_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_list_mem_if
// Purpose  : Bus bundle for edge_list_mem.
//            The bundle carries the random-access port (we/addr/wdata/rdata),
//            the append port (app_*), clear, the scan stream (scan_start,
//            e_*, scan_done) and status (busy, count).
//            - master: the user side, which drives the requests.
//            - slave:  the memory side.
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface edge_list_mem_if #(
  parameter int VW    = 4,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * VW;

  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          app_valid;
  logic [VW-1:0] app_va;
  logic [VW-1:0] app_vb;
  logic          app_ready;
  logic          app_err;
  logic          clear;
  logic          scan_start;
  logic          e_valid;
  logic          e_ready;
  logic [VW-1:0] e_va;
  logic [VW-1:0] e_vb;
  logic [AW-1:0] e_idx;
  logic          scan_done;
  logic          busy;
  logic [AW:0]   count;

  modport master (
    output we, addr, wdata, app_valid, app_va, app_vb, clear, scan_start,
           e_ready,
    input  rdata, app_ready, app_err, e_valid, e_va, e_vb, e_idx, scan_done,
           busy, count
  );

  modport slave (
    input  we, addr, wdata, app_valid, app_va, app_vb, clear, scan_start,
           e_ready,
    output rdata, app_ready, app_err, e_valid, e_va, e_vb, e_idx, scan_done,
           busy, count
  );
endinterface
`default_nettype wire

// File: rtl/edge_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edge_scan_ctrl
// Purpose  : Skip-empty scan engine for edge_list_mem.
//            - Walks ptr over all slots and drives the e_* output register.
//            - Holds the output stable under back-pressure.
//            - Pulses scan_done once the last edge has been drained.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start          - load ptr=0 (scan accepted)
//            in_scan        - controller is in SCAN
//            in_drain       - controller is in DRAIN
//            ptr / word     - memory read address and the data at that address
//            e_*            - output stream; scan_done pulses at scan end
//            last           - slot DEPTH-1 examined this cycle
//            drain_ok       - DRAIN completes this cycle
// Revision : 1.0 - initial parametrised release
// ============================================================================
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int VW    = 4,
  parameter int DEPTH = 128
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start,
  input  wire logic                     in_scan,
  input  wire logic                     in_drain,
  output logic [$clog2(DEPTH)-1:0]      ptr,
  input  wire logic [2*VW-1:0]          word,
  input  wire logic                     e_ready,
  output logic                          e_valid,
  output logic [VW-1:0]                 e_va,
  output logic [VW-1:0]                 e_vb,
  output logic [$clog2(DEPTH)-1:0]      e_idx,
  output logic                          scan_done,
  output logic                          last,
  output logic                          drain_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * VW;
  localparam logic [DW-1:0] EMPTY    = DW'(empty_code(VW));
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q, ptr_d;
  logic          e_valid_q, e_valid_d;
  logic [VW-1:0] e_va_q, e_va_d, e_vb_q, e_vb_d;
  logic [AW-1:0] e_idx_q, e_idx_d;
  logic          scan_done_q, scan_done_d;
  logic          slot_free;

  // The output register can take a new value when it is empty or is being
  // consumed on this edge.
  assign slot_free = !e_valid_q || e_ready;

  always_comb begin
    ptr_d       = ptr_q;
    e_valid_d   = e_valid_q;
    e_va_d      = e_va_q;
    e_vb_d      = e_vb_q;
    e_idx_d     = e_idx_q;
    scan_done_d = 1'b0;
    last        = 1'b0;
    drain_ok    = 1'b0;
    if (start) begin
      ptr_d = '0;
    end
    if (in_scan && slot_free) begin
      if (word != EMPTY) begin
        e_valid_d = 1'b1;
        e_va_d    = VW'(edge_hi(32'(word), VW));
        e_vb_d    = VW'(edge_lo(32'(word), VW));
        e_idx_d   = ptr_q;
      end else begin
        e_valid_d = 1'b0;
      end
      ptr_d = ptr_q + AW'(1);
      last  = (ptr_q == LAST_IDX);
    end
    if (in_drain && slot_free) begin
      e_valid_d   = 1'b0;
      scan_done_d = 1'b1;
      drain_ok    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      e_valid_q   <= 1'b0;
      e_va_q      <= '0;
      e_vb_q      <= '0;
      e_idx_q     <= '0;
      scan_done_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      e_valid_q   <= e_valid_d;
      e_va_q      <= e_va_d;
      e_vb_q      <= e_vb_d;
      e_idx_q     <= e_idx_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign ptr       = ptr_q;
  assign e_valid   = e_valid_q;
  assign e_va      = e_va_q;
  assign e_vb      = e_vb_q;
  assign e_idx     = e_idx_q;
  assign scan_done = scan_done_q;
endmodule
`default_nettype wire

// File: rtl/edge_list_mem.sv
`default_nettype none
// ============================================================================
// Module   : edge_list_mem
// Purpose  : Parametrised edge-list store for the four-colour solver.
//            - Holds {va, vb} edge pairs; all-ones marks an EMPTY slot.
//            - Sequential clear/init writes EMPTY to every slot.
//            - Append port orders the two vertices and rejects self-loops.
//            - Skip-empty scan stream uses a valid/ready handshake.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - edge_list_mem_if.slave (RAM port, append, clear,
//                       scan stream, busy/count status)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module edge_list_mem
  import edge_pkg::*;
#(
  parameter int VW    = 4,
  parameter int DEPTH = 128
) (
  input wire logic        clk,
  input wire logic        rst,
  edge_list_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * VW;
  localparam logic [DW-1:0] EMPTY    = DW'(empty_code(VW));
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          app_err_q, app_err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          app_ready;
  logic [VW-1:0] v_lo, v_hi;
  logic          scan_go, scan_last, drain_ok;
  logic [AW-1:0] scan_ptr;

  // Ready also drops while a higher-priority request is present, so an
  // append is never accepted in the same cycle as clear, scan_start or we.
  assign app_ready = (state_q == ST_IDLE) && !bus.we && !bus.clear &&
                     !bus.scan_start && (count_q < FULL_CNT);
  assign v_lo = (bus.app_va < bus.app_vb) ? bus.app_va : bus.app_vb;
  assign v_hi = (bus.app_va < bus.app_vb) ? bus.app_vb : bus.app_va;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    count_d    = count_q;
    app_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = bus.addr;
    mem_wdata  = bus.wdata;
    scan_go    = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_ptr_q;
        mem_wdata = EMPTY;
        if (init_ptr_q == LAST_IDX) begin
          init_ptr_d = '0;
          state_d    = ST_IDLE;
        end else begin
          init_ptr_d = init_ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
          count_d    = '0;
        end else if (bus.scan_start) begin
          state_d = ST_SCAN;
          scan_go = 1'b1;
        end else if (bus.we) begin
          mem_we = 1'b1;
        end else if (bus.app_valid && app_ready) begin
          if (bus.app_va == bus.app_vb) begin
            app_err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = count_q[AW-1:0];
            mem_wdata = DW'(pack_edge(16'(v_lo), 16'(v_hi), VW));
            count_d   = count_q + (AW + 1)'(1);
          end
        end
      end
      ST_SCAN: begin
        if (scan_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      count_q    <= '0;
      app_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      count_q    <= count_d;
      app_err_q  <= app_err_d;
    end
  end

  // The storage array has no reset of its own; INIT rewrites every slot.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  edge_scan_ctrl #(
    .VW    (VW),
    .DEPTH (DEPTH)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_go),
    .in_scan   (state_q == ST_SCAN),
    .in_drain  (state_q == ST_DRAIN),
    .ptr       (scan_ptr),
    .word      (mem_q[scan_ptr]),
    .e_ready   (bus.e_ready),
    .e_valid   (bus.e_valid),
    .e_va      (bus.e_va),
    .e_vb      (bus.e_vb),
    .e_idx     (bus.e_idx),
    .scan_done (bus.scan_done),
    .last      (scan_last),
    .drain_ok  (drain_ok)
  );

  assign bus.rdata     = mem_q[bus.addr];
  assign bus.app_ready = app_ready;
  assign bus.app_err   = app_err_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.count     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_edge_list_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_list_mem
// Purpose  : Self-checking bench for edge_list_mem (VW=4, DEPTH=128).
//            - A table of append/write/read vectors with hand-computed values.
//            - Hand-written sequences for the multi-cycle cases: init length,
//              scans with and without back-pressure, fill-to-full, clear, and
//              reset during a scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_list_mem;
  localparam int VW    = 4;
  localparam int DEPTH = 128;
  localparam int K_APP = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_list_mem_if #(.VW(VW), .DEPTH(DEPTH)) bus ();

  edge_list_mem #(.VW(VW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int kind;
    int addr;
    int data;
    int va;
    int vb;
    int exp;
    int exp_cnt;
  } vec_t;

  vec_t tbl[11];
  int   exp_idx[4];
  int   exp_dat[4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Counts the cycles spent in INIT (busy high) and checks the DEPTH length.
  // A stray we/append is offered throughout and must be ignored.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    bus.we = 1'b1; bus.addr = 7'd5; bus.wdata = 8'h55;
    while (bus.busy && n < 1000) begin
      check({name, "_app_ready_busy"}, bus.app_ready, 1'b0);
      @(posedge clk); #1;
      n++;
      if (bus.scan_done) check({name, "_no_scan_done"}, 1'b1, 1'b0);
    end
    bus.we = 1'b0;
    check({name, "_busy_cycles"}, n, DEPTH);
    bus.addr = 7'd5; #1;
    check({name, "_we_ignored"}, bus.rdata, 8'hFF);
  endtask

  // Runs one scan with e_ready following pat (bit n%4 in cycle n), checks
  // each transfer against exp_idx/exp_dat, and checks stability while stalled.
  task automatic do_scan(input string name, input logic [3:0] pat,
                         input int exp_n, output int cycles);
    int k;
    int done_seen;
    logic cv;
    logic [6:0] ci;
    logic [3:0] ca, cb;
    bus.scan_start = 1'b1;
    @(posedge clk); #1;
    bus.scan_start = 1'b0;
    cycles = 0; k = 0; done_seen = 0;
    while (cycles < 600 && done_seen == 0) begin
      cv = bus.e_valid; ci = bus.e_idx; ca = bus.e_va; cb = bus.e_vb;
      bus.e_ready = pat[cycles % 4];
      @(posedge clk); #1;
      cycles++;
      if (cv && bus.e_ready) begin
        if (k < exp_n) begin
          check({name, "_idx"}, 32'(ci), exp_idx[k]);
          check({name, "_edge"}, {ca, cb}, exp_dat[k]);
        end else begin
          check({name, "_extra_edge"}, 32'(ci), 32'hFFFF);
        end
        k++;
      end else if (cv) begin
        check({name, "_stall_hold"}, {bus.e_valid, bus.e_idx, bus.e_va, bus.e_vb},
              {1'b1, ci, ca, cb});
      end
      if (bus.scan_done) done_seen = 1;
    end
    bus.e_ready = 1'b1;
    check({name, "_xfers"}, k, exp_n);
    check({name, "_done_seen"}, done_seen, 1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, {bus.scan_done, bus.busy, bus.e_valid}, 3'b000);
  endtask

  initial begin
    int cyc;
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.app_valid = 1'b0; bus.app_va = '0; bus.app_vb = '0;
    bus.clear = 1'b0; bus.scan_start = 1'b0; bus.e_ready = 1'b1;

    tbl[0]  = '{K_APP, 0,  0,    3, 0, 0,    1};
    tbl[1]  = '{K_APP, 0,  0,    2, 1, 0,    2};
    tbl[2]  = '{K_APP, 0,  0,    5, 5, 1,    2};
    tbl[3]  = '{K_RD,  0,  0,    0, 0, 8'h03, 2};
    tbl[4]  = '{K_RD,  1,  0,    0, 0, 8'h12, 2};
    tbl[5]  = '{K_RD,  2,  0,    0, 0, 8'hFF, 2};
    tbl[6]  = '{K_WR,  20, 8'h45, 0, 0, 0,   2};
    tbl[7]  = '{K_WR,  28, 8'h67, 0, 0, 0,   2};
    tbl[8]  = '{K_RD,  20, 0,    0, 0, 8'h45, 2};
    tbl[9]  = '{K_RD,  28, 0,    0, 0, 8'h67, 2};
    tbl[10] = '{K_RD,  29, 0,    0, 0, 8'hFF, 2};

    // Reset state, then INIT length.
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {bus.busy, bus.e_valid, bus.scan_done, bus.app_err},
          4'b1000);
    check("rst_count", bus.count, 0);
    rst = 1'b0;
    wait_init("init");
    foreach (exp_idx[i]) exp_idx[i] = 0;
    bus.addr = 7'd0;   #1; check("init_rd0", bus.rdata, 8'hFF);
    bus.addr = 7'd64;  #1; check("init_rd64", bus.rdata, 8'hFF);
    bus.addr = 7'd127; #1; check("init_rd127", bus.rdata, 8'hFF);
    check("init_count", bus.count, 0);

    // Table-driven appends, writes and reads.
    for (int i = 0; i < 11; i++) begin
      case (tbl[i].kind)
        K_APP: begin
          bus.app_valid = 1'b1;
          bus.app_va = 4'(tbl[i].va); bus.app_vb = 4'(tbl[i].vb);
          #1;
          check("app_ready", bus.app_ready, 1'b1);
          @(posedge clk); #1;
          bus.app_valid = 1'b0;
          check("app_err", bus.app_err, tbl[i].exp);
          check("app_count", bus.count, tbl[i].exp_cnt);
          @(posedge clk); #1;
          check("app_err_clear", bus.app_err, 1'b0);
        end
        K_WR: begin
          bus.we = 1'b1; bus.addr = 7'(tbl[i].addr); bus.wdata = 8'(tbl[i].data);
          @(posedge clk); #1;
          bus.we = 1'b0;
          check("wr_count", bus.count, tbl[i].exp_cnt);
        end
        default: begin
          bus.addr = 7'(tbl[i].addr); #1;
          check("rd_data", bus.rdata, tbl[i].exp);
          check("rd_count", bus.count, tbl[i].exp_cnt);
        end
      endcase
    end

    // Sparse scan, consumer always ready: exact timing.
    exp_idx = '{0, 1, 20, 28};
    exp_dat = '{8'h03, 8'h12, 8'h45, 8'h67};
    do_scan("scan_ready", 4'b1111, 4, cyc);
    check("scan_cycles", cyc, DEPTH + 1);

    // Same contents under back-pressure 1-0-0-1.
    do_scan("scan_bp", 4'b1001, 4, cyc);

    // Fill to full: slots 2..127 get va=i[3:0], vb=~va.
    for (int i = 2; i < DEPTH; i++) begin
      bus.app_valid = 1'b1;
      bus.app_va = 4'(i); bus.app_vb = ~4'(i);
      @(posedge clk); #1;
    end
    #1;
    check("full_count", bus.count, DEPTH);
    check("full_ready", bus.app_ready, 1'b0);
    @(posedge clk); #1;
    bus.app_valid = 1'b0;
    check("full_count_hold", bus.count, DEPTH);
    bus.addr = 7'd100; #1; check("full_rd100", bus.rdata, 8'h4B);
    bus.addr = 7'd127; #1; check("full_rd127", bus.rdata, 8'h0F);

    // Clear, then an all-EMPTY scan.
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check("clear_count", bus.count, 0);
    wait_init("clear");
    do_scan("scan_empty", 4'b1111, 0, cyc);
    check("scan_empty_cycles", cyc, DEPTH + 1);

    // Reset during a scan.
    bus.app_valid = 1'b1; bus.app_va = 4'd1; bus.app_vb = 4'd2;
    @(posedge clk); #1;
    bus.app_valid = 1'b0;
    bus.scan_start = 1'b1;
    @(posedge clk); #1;
    bus.scan_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_scan_outputs", {bus.e_valid, bus.scan_done, bus.busy}, 3'b001);
    check("rst_scan_count", bus.count, 0);
    rst = 1'b0;
    wait_init("rst_init");
    do_scan("scan_after_rst", 4'b1111, 0, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
